// File: rtl/switch_mode_selector.sv
// switch_mode_selector
// Front-panel switch decoder for the RTC controller. Each raw switch is
// synchronised with two flops and debounced. The resulting debounced vector
// is encoded into a registered programming-mode code: 0 = idle, i+1 = switch i.
// The block also provides a conflict flag and a one-cycle mode-change pulse.
//
// Build option: define SWITCH_LATCH_EN to select toggle mode. In toggle mode
// an isolated press of switch i flips the mode between i+1 and 0. When the
// macro is undefined the block uses follow mode: the mode tracks the single
// active switch.
module switch_mode_selector #(
    parameter int N_SW            = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MODE_W          = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SW-1:0]   sw,
    output logic [MODE_W-1:0] mode_out,
    output logic              mode_changed,
    output logic              conflict
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_W  = $clog2(N_SW + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]   sync1_r;
    logic [N_SW-1:0]   sync2_r;
    logic [N_SW-1:0]   db_r;
    logic [CNT_W-1:0]  cnt_r [N_SW];

    logic [HC_W-1:0]   hot_cnt_s;
    logic [MODE_W-1:0] hot_idx_s;
    logic              conflict_s;
    logic [MODE_W-1:0] mode_nxt_s;

    logic [MODE_W-1:0] mode_r;
    logic              changed_r;
    logic              conflict_r;

    // Two-flop synchroniser bringing the asynchronous switch levels into clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {N_SW{1'b0}};
            sync2_r <= {N_SW{1'b0}};
        end else begin
            sync1_r <= sw;
            sync2_r <= sync1_r;
        end
    end

    // Per-switch debounce: accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_r <= {N_SW{1'b0}};
            for (int i = 0; i < N_SW; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_SW; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_LAST) begin
                    db_r[i]  <= sync2_r[i];
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Count the active debounced switches and find the highest active index.
    always_comb begin
        hot_cnt_s = {HC_W{1'b0}};
        hot_idx_s = {MODE_W{1'b0}};
        for (int i = 0; i < N_SW; i++) begin
            hot_cnt_s = hot_cnt_s + HC_W'(db_r[i]);
            hot_idx_s = db_r[i] ? MODE_W'(i + 1) : hot_idx_s;
        end
        conflict_s = (hot_cnt_s > HC_W'(1));
    end

`ifdef SWITCH_LATCH_EN
    logic [N_SW-1:0] db_prev_r;
    logic [N_SW-1:0] rise_s;

    // Remember the previous debounced vector so that press edges can be detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_prev_r <= {N_SW{1'b0}};
        end else begin
            db_prev_r <= db_r;
        end
    end

    // Toggle mode: an isolated press toggles between idle and that switch's mode.
    always_comb begin
        rise_s     = db_r & ~db_prev_r;
        mode_nxt_s = mode_r;
        if ((hot_cnt_s == HC_W'(1)) && (rise_s != {N_SW{1'b0}})) begin
            if (mode_r == hot_idx_s) begin
                mode_nxt_s = {MODE_W{1'b0}};
            end else begin
                mode_nxt_s = hot_idx_s;
            end
        end else begin
            mode_nxt_s = mode_r;
        end
    end
`else
    // Follow mode: idle when no switch is active, the switch's mode when exactly one is active, hold on conflict.
    always_comb begin
        mode_nxt_s = mode_r;
        if (hot_cnt_s == {HC_W{1'b0}}) begin
            mode_nxt_s = {MODE_W{1'b0}};
        end else if (hot_cnt_s == HC_W'(1)) begin
            mode_nxt_s = hot_idx_s;
        end else begin
            mode_nxt_s = mode_r;
        end
    end
`endif

    // Output registers: mode code, conflict level and change pulse all update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r     <= {MODE_W{1'b0}};
            changed_r  <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            mode_r     <= mode_nxt_s;
            changed_r  <= (mode_nxt_s != mode_r);
            conflict_r <= conflict_s;
        end
    end

    assign mode_out     = mode_r;
    assign mode_changed = changed_r;
    assign conflict     = conflict_r;

endmodule

// File: doc/switch_mode_selector.md
# switch_mode_selector

Parametrised front-panel switch decoder for the RTC controller. Synchronises and debounces N_SW raw slide/push switches and encodes the single active switch into a registered programming-mode code. Flags conflicting switch combinations and pulses on every mode change. Sits between the board switch pins and the RTC control FSM, which consumes `mode_out` and `mode_changed`.

## Interface

- `N_SW`, default 3: number of switch inputs; legal range 1..15.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a switch change is accepted; must be ≥ 1.
- `MODE_W`, default 2: width of the mode code; must satisfy 2^MODE_W ≥ N_SW+1.

- `clk`  input  1: system clock, rising-edge active.
- `reset`  input  1: asynchronous, active-high reset.
- `sw`  input  N_SW: raw switch levels, asynchronous to `clk`, active high.
- `mode_out`  output  MODE_W: registered mode code; 0 = idle, i+1 = switch i selected.
- `mode_changed`  output  1: one-cycle pulse, high in the cycle `mode_out` takes a new value.
- `conflict`  output  1: registered level, high while more than one debounced switch is high.

## Operation

- Per switch: 2-flop synchroniser → debounce stage → debounced level `db[i]`.
- Debounce: counter of width clog2(DEBOUNCE_CYCLES+1); clears whenever the synchroniser output equals `db[i]`; increments while they differ; when it would reach DEBOUNCE_CYCLES, `db[i]` takes the synchroniser value and the counter clears.
- Any excursion shorter than DEBOUNCE_CYCLES cycles at the synchroniser output is discarded.
- Encoder (default build, follow mode):
  - `db` all zero → next mode 0.
  - exactly one bit `db[i]` high → next mode i+1.
  - two or more bits high → mode holds its current value; `conflict` = 1.
- `conflict` is registered from the same `db` vector, updated in lockstep with `mode_out`.
- `mode_changed` = 1 exactly in the cycle following a clock edge at which `mode_out` changed value; never asserted by reset.
- Reset (asynchronous, immediate): synchronisers, `db`, counters cleared to 0; `mode_out` = 0, `mode_changed` = 0, `conflict` = 0.
- Reset mid-operation: outputs clear immediately; a switch still held at deassertion is re-synchronised and re-debounced from zero, with no shortcut.

## Timing

- Clean step on `sw[i]` applied between edges: `db[i]` updates on rising edge 2+DEBOUNCE_CYCLES; `mode_out`, `conflict` and `mode_changed` update on edge DEBOUNCE_CYCLES+3. For the default build that is 7 edges.
- Two switches changing on the same cycle are decoded in the same cycle. The transient `db` combination is decoded as-is, so 01→10 through 11 holds mode and pulses `conflict`.
- `mode_changed` width is exactly one `clk` cycle. Back-to-back changes on consecutive cycles produce consecutive pulses.
- No combinational path from `sw` to any output.

## Configuration

- `SWITCH_LATCH_EN` defined (toggle mode):
  - A rising edge of `db[i]` while no other `db` bit is high toggles the mode: the mode becomes 0 if it was i+1, otherwise i+1.
  - Releasing a switch does not change the mode.
  - Rising edges while `conflict` is high are ignored.
  - A switch still held after reset counts as a rising edge once debounced.
- `SWITCH_LATCH_EN` undefined: follow mode as described in Operation. The toggle logic and the `db` edge-detect registers are not compiled in.

## Test plan

All scenarios use N_SW=3, DEBOUNCE_CYCLES=4, MODE_W=2.

- Reset, then `sw`=001 set between edges → `mode_out`=1 and a single `mode_changed` pulse at edge 7. Then `sw`=000 → `mode_out`=0 at edge 7 after release, with one pulse.
- `sw[1]` high for 3 cycles, then low → `mode_out` stays 0, `mode_changed` never asserted, `conflict` stays 0.
- With `mode_out`=1, set `sw`=011 → `conflict`=1 after 7 edges; `mode_out` stays 1 with no pulse. Return `sw` to 001 → `conflict`=0.
- Walk `sw` through 001, 010, 100, each held 12 cycles → `mode_out` goes 1, 2, 3 with exactly three pulses.
- With `mode_out`=2 and `sw`=010 held, assert `reset` mid-cycle → all outputs 0 immediately with no pulse. Deassert → `mode_out`=2 after 7 edges, with one pulse.
- `SWITCH_LATCH_EN` build: press `sw[2]` for 10 cycles, then release → `mode_out`=3 and stays 3. Press again → `mode_out`=0. Press `sw`=011 together → mode unchanged, `conflict`=1.
